// File: rtl/accum_sum_fifo.sv
// Sum-capture FIFO behind the Data/RegSum accumulator: stores Data+RegSum with carry,
// presents entries on a registered valid/ready head, and tracks sticky overflow/drop stats.
module accum_sum_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         Data,
    input  logic [WIDTH-1:0]         RegSum,
    input  logic                     InValid,
    output logic [WIDTH:0]           OutData,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow,
    output logic [CNT_W-1:0]         DropCount,
    input  logic                     ClearStats
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_out_data;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH:0]   w_entry;
    logic [AW-1:0]    w_rd_next;
    logic [WIDTH:0]   w_head_next;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty & OutReady;
    assign w_push    = InValid & (!w_full | w_pop);
    assign w_drop    = InValid & w_full & !w_pop;
    assign w_entry   = {1'b0, Data} + {1'b0, RegSum};
    assign w_rd_next = r_rd_ptr + AW'(1);

    // Head register is preloaded with whatever entry will be at the read pointer after
    // this edge, so a lone entry replaced by a same-cycle push appears with no bubble.
    always_comb begin
        w_head_next = r_out_data;
        if (w_pop) begin
            if (r_count == CW'(1))
                w_head_next = w_push ? w_entry : '0;
            else
                w_head_next = r_mem[w_rd_next];
        end else if (w_empty && w_push) begin
            w_head_next = w_entry;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_data <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= w_rd_next;
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            r_out_data <= w_head_next;

            if (ClearStats) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else begin
                if (w_push && w_entry[WIDTH])
                    r_overflow <= 1'b1;
                if (w_drop && (r_drop_cnt != '1))
                    r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign OutData   = r_out_data;
    assign OutValid  = !w_empty;
    assign Count     = r_count;
    assign Full      = w_full;
    assign Empty     = w_empty;
    assign Overflow  = r_overflow;
    assign DropCount = r_drop_cnt;

endmodule

// File: tb/tb_accum_sum_fifo.sv
// Directed bench for accum_sum_fifo: queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_accum_sum_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic [WIDTH-1:0] Data = '0;
    logic [WIDTH-1:0] RegSum = '0;
    logic             InValid = 1'b0;
    logic [WIDTH:0]   OutData;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [2:0]       Count;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic [CNT_W-1:0] DropCount;
    logic             ClearStats = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    accum_sum_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .Data(Data), .RegSum(RegSum), .InValid(InValid),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady), .Count(Count),
        .Full(Full), .Empty(Empty), .Overflow(Overflow), .DropCount(DropCount),
        .ClearStats(ClearStats)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: contents as a plain queue, stats as integers.
    int m_q[$];
    int m_ovf  = 0;
    int m_drop = 0;
    bit started = 0;

    always @(posedge Clock) begin
        int  entry;
        bit  full, pop, push, drop;
        started = 1;
        if (!Reset) begin
            m_q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            entry = int'(Data) + int'(RegSum);
            full  = (m_q.size() == DEPTH);
            pop   = (m_q.size() > 0) && OutReady;
            push  = InValid && (!full || pop);
            drop  = InValid && full && !pop;
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(entry);
            if (ClearStats) begin
                m_ovf  = 0;
                m_drop = 0;
            end else begin
                if (push && entry >= 16) m_ovf = 1;
                if (drop && m_drop < 255) m_drop++;
            end
        end
    end

    always @(negedge Clock) begin
        if (started) begin
            chk("m_count", int'(Count), m_q.size());
            chk("m_full", int'(Full), int'(m_q.size() == DEPTH));
            chk("m_empty", int'(Empty), int'(m_q.size() == 0));
            chk("m_outvalid", int'(OutValid), int'(m_q.size() > 0));
            if (m_q.size() > 0) chk("m_outdata", int'(OutData), m_q[0]);
            chk("m_overflow", int'(Overflow), m_ovf);
            chk("m_dropcount", int'(DropCount), m_drop);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        // Reset held 3 cycles with a valid sample present
        Reset = 1'b0; InValid = 1'b1; Data = 4'd3; RegSum = 4'd5;
        cyc(3);
        chk("rst_count", int'(Count), 0);
        chk("rst_empty", int'(Empty), 1);
        chk("rst_full", int'(Full), 0);
        chk("rst_outvalid", int'(OutValid), 0);
        chk("rst_outdata", int'(OutData), 0);
        chk("rst_overflow", int'(Overflow), 0);
        chk("rst_drop", int'(DropCount), 0);

        // 3+5 single push
        Reset = 1'b1;
        cyc(1);
        InValid = 1'b0;
        chk("p1_outvalid", int'(OutValid), 1);
        chk("p1_outdata", int'(OutData), 'h08);
        chk("p1_count", int'(Count), 1);
        chk("p1_overflow", int'(Overflow), 0);
        cyc(2);
        chk("p1_hold", int'(OutData), 'h08);
        OutReady = 1'b1;
        cyc(1);
        OutReady = 1'b0;
        chk("p1_popped", int'(Empty), 1);

        // 9+9 carries out
        Data = 4'd9; RegSum = 4'd9; InValid = 1'b1;
        cyc(1);
        InValid = 1'b0;
        chk("c_outdata", int'(OutData), 'h12);
        chk("c_overflow", int'(Overflow), 1);
        OutReady = 1'b1;
        cyc(1);
        OutReady = 1'b0;
        chk("c_ovf_after_pop", int'(Overflow), 1);
        ClearStats = 1'b1;
        cyc(1);
        ClearStats = 1'b0;
        chk("c_cleared", int'(Overflow), 0);

        // 6 samples into a stalled FIFO: entries 2,4,...,12, last two dropped
        InValid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            Data = 4'(i); RegSum = 4'(i);
            cyc(1);
        end
        InValid = 1'b0;
        chk("f_full", int'(Full), 1);
        chk("f_drop", int'(DropCount), 2);
        OutReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("f_drain", int'(OutData), 2 * (k + 1));
            cyc(1);
        end
        OutReady = 1'b0;
        chk("f_drained", int'(Empty), 1);

        // Fill with 1..4, then 8 cycles of simultaneous push/pop at full
        RegSum = 4'd0; InValid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            Data = 4'(k);
            cyc(1);
        end
        OutReady = 1'b1; RegSum = 4'd1;
        for (int k = 0; k < 8; k++) begin
            Data = 4'(5 + k);
            chk("s_count", int'(Count), 4);
            chk("s_order", int'(OutData), (k < 4) ? k + 1 : k + 2);
            cyc(1);
        end
        chk("s_drop_same", int'(DropCount), 2);
        chk("s_count_end", int'(Count), 4);

        // Saturating drops against a full, stalled FIFO
        OutReady = 1'b0;
        cyc(300);
        chk("sat_drop", int'(DropCount), 'hFF);
        chk("sat_head", int'(OutData), 10);
        ClearStats = 1'b1;
        cyc(1);
        chk("clr_vs_drop", int'(DropCount), 0);

        // ClearStats beats a same-cycle carrying push
        ClearStats = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        cyc(1);
        OutReady = 1'b0; InValid = 1'b1; Data = 4'd15; RegSum = 4'd15; ClearStats = 1'b1;
        cyc(1);
        InValid = 1'b0; ClearStats = 1'b0;
        chk("clr_vs_carry", int'(Overflow), 0);
        chk("clr_keeps_data", int'(Count), 4);

        // Reset mid-occupancy discards everything
        OutReady = 1'b1;
        cyc(1);
        OutReady = 1'b0;
        chk("pre_rst_count", int'(Count), 3);
        Reset = 1'b0;
        cyc(1);
        Reset = 1'b1;
        chk("mid_rst_count", int'(Count), 0);
        chk("mid_rst_valid", int'(OutValid), 0);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
